// File: rtl/psram_req_pkg.sv
// Shared definitions for the clk32 PSRAM request path: widths, FSM encoding,
// port identifiers and the latched request record.
package psram_req_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_ARM       = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/psram_req_arbiter.sv
// Fixed-priority A/B grant with a starvation counter that forces B after
// STARVE_LIMIT consecutive A grants taken while B was waiting.
module psram_req_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic clk32,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    input  logic grant_en,
    output logic grant_a,
    output logic grant_b
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          force_b;

    assign force_b = b_req && (starve_cnt == LIMIT);
    assign grant_a = grant_en && a_req && !force_b;
    assign grant_b = grant_en && b_req && (!a_req || force_b);

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_b) begin
            starve_cnt <= '0;
        end else if (grant_a) begin
            if (!b_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/psram_requester.sv
// Two-client request sequencer for the clk32 PSRAM interface: one strobe per
// grant, address/data held to completion, read data returned with a 1-cycle ack.
module psram_requester
    import psram_req_pkg::*;
#(
    parameter int GUARD        = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy
);

    localparam int GW = $clog2(GUARD + 1);

    logic [1:0]    state;
    logic [GW-1:0] guard_cnt;
    req_t          cur;
    req_t          nxt;
    logic          grant_en;
    logic          grant_a;
    logic          grant_b;

    // A req still high in the ack cycle is a fresh request; hold it off one cycle.
    assign grant_en = (state == ST_IDLE) && !mem_busy && !a_ack && !b_ack;

    psram_req_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arbiter (
        .clk32   (clk32),
        .reset   (reset),
        .a_req   (a_req),
        .b_req   (b_req),
        .grant_en(grant_en),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_comb begin
        nxt = cur;
        if (grant_b) begin
            nxt.port  = PORT_B;
            nxt.we    = b_we;
            nxt.addr  = b_addr;
            nxt.wdata = b_wdata;
        end else if (grant_a) begin
            nxt.port  = PORT_A;
            nxt.we    = 1'b0;
            nxt.addr  = a_addr;
            nxt.wdata = '0;
        end
    end

    assign mem_addr       = cur.addr;
    assign mem_din        = cur.wdata;
    assign mem_byte_write = 1'b0;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
            cur       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Strobe is registered here so it lands in the ISSUE cycle.
                    if (grant_a || grant_b) begin
                        cur       <= nxt;
                        mem_read  <= !nxt.we;
                        mem_write <= nxt.we;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    guard_cnt <= GW'(GUARD - 1);
                    state     <= ST_ARM;
                end
                ST_ARM: begin
                    // Busy is still crossing from the memory domain; ignore it.
                    if (guard_cnt == '0) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!mem_busy) begin
                        if (!cur.we) begin
                            if (cur.port == PORT_A) begin
                                a_rdata <= mem_dout;
                            end else begin
                                b_rdata <= mem_dout;
                            end
                        end
                        a_ack <= (cur.port == PORT_A);
                        b_ack <= (cur.port == PORT_B);
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_requester.sv
// Bench for psram_requester: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_psram_requester;
    import psram_req_pkg::*;

    localparam int GUARD        = 4;
    localparam int STARVE_LIMIT = 2;

    logic              clk32 = 1'b0;
    logic              reset;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              mem_read;
    logic              mem_write;
    logic              mem_byte_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_busy;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] ex_ard;
    logic [DATA_W-1:0] ex_brd;

    typedef struct {
        logic              port_b;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                busy_len;
        logic [DATA_W-1:0] dout;
        int                exp_ack;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    psram_requester #(
        .GUARD(GUARD),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk32(clk32), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_read"}, mem_read, 0);
        check({tag, " mem_write"}, mem_write, 0);
        check({tag, " mem_byte_write"}, mem_byte_write, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_din"}, mem_din, 0);
        check({tag, " a_ack"}, a_ack, 0);
        check({tag, " b_ack"}, b_ack, 0);
        check({tag, " a_rdata"}, a_rdata, 0);
        check({tag, " b_rdata"}, b_rdata, 0);
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        mem_busy = 1'b0; mem_dout = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        ex_ard = '0;
        ex_brd = '0;
        reset = 1'b0;
        tick();
    endtask

    // One isolated transaction from the vector table; cycle 0 is the grant cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int strobes = 0;
        int ack_at  = -1;
        mem_busy = 1'b0;
        mem_dout = v.dout;
        if (v.port_b) begin
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1'b1; a_addr = v.addr;
        end
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            tick();
            mem_busy = (c >= 2) && (c <= 1 + v.busy_len);
            if (mem_read || mem_write) begin
                strobes++;
                check({tag, " strobe_cycle"}, c, 1);
                check({tag, " strobe_op"}, {mem_read, mem_write}, v.we ? 2'b01 : 2'b10);
            end
            check({tag, " byte_write"}, mem_byte_write, 0);
            check({tag, " mem_addr"}, mem_addr, v.addr);
            if (v.we) check({tag, " mem_din"}, mem_din, v.wdata);
            if (c == 1) begin
                a_addr = ~v.addr; b_addr = ~v.addr; b_wdata = ~v.wdata;
            end
            if (a_ack || b_ack) begin
                ack_at = c;
                check({tag, " ack_port"}, {a_ack, b_ack}, v.port_b ? 2'b01 : 2'b10);
                check({tag, " ack_cycle"}, c, v.exp_ack);
                if (!v.we) begin
                    if (v.port_b) ex_brd = v.exp_rdata;
                    else ex_ard = v.exp_rdata;
                end
                a_req = 1'b0;
                b_req = 1'b0;
            end
            check({tag, " a_rdata"}, a_rdata, ex_ard);
            check({tag, " b_rdata"}, b_rdata, ex_brd);
        end
        check({tag, " ack_seen"}, ack_at >= 0, 1);
        check({tag, " strobe_count"}, strobes, 1);
        a_req = 1'b0; b_req = 1'b0; mem_busy = 1'b0;
        tick();
        tick();
    endtask

    task automatic busy_after_reset();
        idle_inputs();
        reset = 1'b1;
        mem_busy = 1'b1;
        mem_dout = 16'h5A5A;
        a_req = 1'b1;
        a_addr = 22'h00ABCD;
        tick();
        ex_ard = '0; ex_brd = '0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy_hold no_strobe", mem_read || mem_write, 0);
        end
        mem_busy = 1'b0;
        tick();
        check("busy_release strobe", mem_read, 1);
        check("busy_release addr", mem_addr, 22'h00ABCD);
        for (int c = 2; c <= 7; c++) begin
            tick();
            check("busy_release a_ack", a_ack, c == 7);
            if (c == 7) begin
                check("busy_release a_rdata", a_rdata, 16'h5A5A);
                a_req = 1'b0;
                ex_ard = 16'h5A5A;
            end
        end
        tick();
    endtask

    task automatic reset_in_arm();
        idle_inputs();
        mem_dout = 16'h1111;
        a_req = 1'b1;
        a_addr = 22'h000777;
        tick();
        check("rst_arm strobe", mem_read, 1);
        tick();
        tick();
        a_req = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("rst_arm async");
        tick();
        ex_ard = '0; ex_brd = '0;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rst_arm no_ack", a_ack || b_ack, 0);
            check("rst_arm no_strobe", mem_read || mem_write, 0);
        end
    endtask

    task automatic starvation();
        int order[6];
        int exp_order[6];
        int nack = 0;
        exp_order = '{0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 6; i++) order[i] = -1;
        idle_inputs();
        mem_dout = 16'hC0DE;
        a_req = 1'b1; a_addr = 22'h0000AA;
        b_req = 1'b1; b_we = 1'b0; b_addr = 22'h0000BB;
        for (int c = 1; c <= 80 && nack < 6; c++) begin
            tick();
            check("starve no_overlap", a_ack && b_ack, 0);
            if (a_ack || b_ack) begin
                order[nack] = b_ack ? 1 : 0;
                nack++;
                if (nack == 6) begin
                    a_req = 1'b0;
                    b_req = 1'b0;
                end
            end
        end
        check("starve ack_count", nack, 6);
        for (int i = 0; i < 6; i++) check($sformatf("starve order[%0d]", i), order[i], exp_order[i]);
        tick();
        tick();
    endtask

    // Reference model: transactions, per-port expected rdata, grant rule by
    // plain counting. Each cycle: predicted strobe, op/addr, ack cycle, rdata.
    task automatic random_phase(input int ncycles);
        int   starve = 0;
        bit   in_flight = 0;
        bit   exp_strobe = 0;
        bit   fl_port_b = 0;
        bit   fl_we = 0;
        bit   win_b;
        bit   strobe;
        logic [ADDR_W-1:0] fl_addr = '0;
        logic [DATA_W-1:0] fl_wdata = '0;
        logic [DATA_W-1:0] fl_dout = '0;
        int   fl_len = 0;
        int   strobe_cyc = 0;
        int   exp_ack = 0;
        idle_inputs();
        do_reset();
        for (int c = 0; c < ncycles; c++) begin
            tick();
            strobe = mem_read || mem_write;
            check("rnd strobe", strobe, exp_strobe);
            check("rnd ack_overlap", a_ack && b_ack, 0);
            if (strobe && exp_strobe) begin
                win_b = b_req && (!a_req || starve == STARVE_LIMIT);
                fl_port_b = win_b;
                fl_we     = win_b ? b_we : 1'b0;
                fl_addr   = win_b ? b_addr : a_addr;
                fl_wdata  = b_wdata;
                if (win_b) starve = 0;
                else if (b_req) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
                else starve = 0;
                check("rnd strobe_op", {mem_read, mem_write}, fl_we ? 2'b01 : 2'b10);
                in_flight  = 1;
                strobe_cyc = c;
                fl_len     = $urandom_range(0, 9);
                fl_dout    = DATA_W'($urandom);
                exp_ack    = c + ((fl_len > GUARD) ? fl_len : GUARD) + 2;
            end
            if (in_flight) begin
                check("rnd mem_addr_stable", mem_addr, fl_addr);
                if (fl_we) check("rnd mem_din_stable", mem_din, fl_wdata);
            end
            if (a_ack || b_ack) begin
                check("rnd ack_in_flight", in_flight, 1);
                if (in_flight) begin
                    check("rnd ack_port", {a_ack, b_ack}, fl_port_b ? 2'b01 : 2'b10);
                    check("rnd ack_cycle", c, exp_ack);
                    if (!fl_we) begin
                        if (fl_port_b) ex_brd = fl_dout;
                        else ex_ard = fl_dout;
                    end
                    in_flight = 0;
                    if ($urandom_range(0, 3) != 0) begin
                        if (fl_port_b) b_req = 1'b0;
                        else a_req = 1'b0;
                    end
                end
            end else if (in_flight && c > exp_ack) begin
                check("rnd ack_timeout", c, exp_ack);
                in_flight = 0;
            end
            check("rnd a_rdata", a_rdata, ex_ard);
            check("rnd b_rdata", b_rdata, ex_brd);
            // Drive this cycle's inputs.
            if (in_flight) begin
                mem_busy = (c - strobe_cyc >= 1) && (c - strobe_cyc <= fl_len);
                mem_dout = fl_dout;
            end else begin
                mem_busy = ($urandom_range(0, 3) == 0);
                mem_dout = DATA_W'($urandom);
            end
            if (!a_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    a_req = 1'b1;
                    a_addr = ADDR_W'($urandom);
                end
            end else if (in_flight && !fl_port_b && $urandom_range(0, 1) == 0) begin
                a_addr = ADDR_W'($urandom);
            end
            if (!b_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    b_req = 1'b1;
                    b_we = 1'($urandom_range(0, 1));
                    b_addr = ADDR_W'($urandom);
                    b_wdata = DATA_W'($urandom);
                end
            end else if (in_flight && fl_port_b && $urandom_range(0, 1) == 0) begin
                b_addr = ADDR_W'($urandom);
                b_wdata = DATA_W'($urandom);
            end
            exp_strobe = !in_flight && !(a_ack || b_ack) && !mem_busy && (a_req || b_req);
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 22'h000123, 16'h0000, 8,  16'hBEEF, 11, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 22'h3FFFFF, 16'hA5A5, 0,  16'h9999, 7,  16'h0000};
        tbl[2] = '{1'b1, 1'b0, 22'h000001, 16'h0000, 0,  16'h1234, 7,  16'h1234};
        tbl[3] = '{1'b0, 1'b0, 22'h2AAAAA, 16'h0000, 4,  16'h0F0F, 7,  16'h0F0F};
        tbl[4] = '{1'b0, 1'b0, 22'h155555, 16'h0000, 5,  16'h8001, 8,  16'h8001};
        tbl[5] = '{1'b1, 1'b1, 22'h000000, 16'hFFFF, 3,  16'h4321, 7,  16'h0000};
        tbl[6] = '{1'b1, 1'b0, 22'h3FFFFF, 16'h0000, 12, 16'h7FFE, 15, 16'h7FFE};
        tbl[7] = '{1'b0, 1'b0, 22'h3FFFFF, 16'h0000, 0,  16'h0000, 7,  16'h0000};

        idle_inputs();
        ex_ard = '0;
        ex_brd = '0;
        reset = 1'b1;
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("after_reset");

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        busy_after_reset();
        reset_in_arm();
        run_vec(tbl[0], "post_reset");
        starvation();
        random_phase(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psram_requester.md
# psram_requester

Single-clock (clk32) request sequencer that sits on the initiator side of the clk32 PSRAM access interface (read/write strobes, addr, din, dout, busy). It arbitrates two clients, a high-priority VIC-II fetch read port (A) and a host read/write port (B). For each granted request it issues exactly one strobe, holds address and data stable, and tracks busy to completion. It then returns captured read data with a one-cycle acknowledge.

## Interface
- GUARD, 4: cycles after the strobe during which mem_busy is ignored, covering the CDC delay before busy rises; must be ≥1.
- STARVE_LIMIT, 2: consecutive A grants allowed while B is pending before B is forced; must be ≥1.
- clk32  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A read request, level, held until a_ack.
- a_addr  in  22  port A word address.
- a_ack  out  1  one-cycle completion pulse.
- a_rdata  out  16  read data, valid from the a_ack cycle and held until the next A completion.
- b_req  in  1  port B request, level.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  22  port B word address.
- b_wdata  in  16  port B write data.
- b_ack  out  1  one-cycle completion pulse.
- b_rdata  out  16  read data, updated only on B reads.
- mem_read  out  1  one-cycle read strobe.
- mem_write  out  1  one-cycle write strobe.
- mem_byte_write  out  1  constant 0 (full-word writes).
- mem_addr  out  22  address, stable from strobe to completion.
- mem_din  out  16  write data, stable from strobe to completion.
- mem_dout  in  16  read data, valid when mem_busy is low after an access.
- mem_busy  in  1  downstream busy.

## Operation
- States: IDLE, ISSUE, ARM, WAIT_DONE.
- IDLE: grants only when mem_busy = 0 and a request is pending.
  - Arbitration: A wins, unless B is pending and starve_cnt = STARVE_LIMIT; then B wins.
  - Latches port id, op, addr and wdata into registers that drive mem_addr and mem_din. Goes to ISSUE.
- ISSUE: asserts mem_read or mem_write for exactly one cycle, loads guard_cnt = GUARD - 1, goes to ARM.
- ARM: decrements guard_cnt; when it reaches 0, goes to WAIT_DONE. mem_busy is ignored in this state.
- WAIT_DONE: on the first cycle with mem_busy = 0:
  - For reads, registers mem_dout into the granted port's rdata.
  - Pulses that port's ack in the next cycle.
  - Returns to IDLE.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on an A grant while b_req = 1, saturating at STARVE_LIMIT.
  - Clears on a B grant, and on an A grant while b_req = 0.
- A client that drops its req mid-operation does not abort the access. The ack still pulses and the client ignores it.
- A req still high in the ack cycle is treated as a new request. The earliest re-grant is the cycle after ack.
- Address and write data are sampled only at grant. Later changes on a_addr, b_addr or b_wdata have no effect on the access in flight.

## Timing
- Reset values: all outputs 0 (mem_addr, mem_din, a_rdata, b_rdata = 0), state IDLE, starve_cnt = 0.
- Cycle numbering from the grant cycle (cycle 0, IDLE sampling req):
  - Strobe in cycle 1.
  - ARM in cycles 2..GUARD+1.
  - WAIT_DONE from cycle GUARD+2.
  - With mem_busy already low there, ack in cycle GUARD+3. Minimum latency is 7 cycles at GUARD = 4.
  - Each cycle mem_busy stays high in WAIT_DONE delays the ack by one cycle.
- Simultaneous a_req and b_req in IDLE: A is granted unless the starvation rule applies.
- a_ack and b_ack are never high in the same cycle.
- Reset mid-operation: immediate return to IDLE with outputs cleared. The downstream access finishes unobserved. Because IDLE requires mem_busy = 0, no new strobe overlaps it.
- No timeout: if mem_busy stays high forever, the block stays in WAIT_DONE.

## Structure
- Shared package psram_req_pkg holds:
  - the state encoding (IDLE/ISSUE/ARM/WAIT_DONE);
  - port id constants PORT_A = 0, PORT_B = 1;
  - the ADDR_W = 22 and DATA_W = 16 constants used by both this block and the clk32 memory interface.
- One sub-module: psram_req_arbiter. It is combinational grant selection plus the starve_cnt register, with inputs a_req, b_req, grant_en and outputs grant_a, grant_b.

## Test plan
- A read only, a_addr = 0x00123, mem_busy high for cycles 2–9, mem_dout = 0xBEEF:
  - mem_read pulses in cycle 1 with mem_addr = 0x00123.
  - a_ack pulses in cycle 11 with a_rdata = 0xBEEF.
- B write, b_addr = 0x3FFFFF, b_wdata = 0xA5A5, busy never asserted:
  - mem_write pulses once and mem_byte_write = 0.
  - b_ack pulses in cycle 7.
  - b_rdata stays unchanged.
- a_req and b_req held continuously (B read), STARVE_LIMIT = 2: grant order is A, A, B, A, A, B; no ack overlap.
- Requests asserted while mem_busy is high after reset:
  - No strobe until busy falls.
  - First grant occurs in the first IDLE cycle with mem_busy = 0.
- reset asserted in ARM during an A read:
  - All outputs go to 0 the same cycle and a_ack never pulses.
  - A new request issues normally after reset releases and busy is low.
- b_addr and b_wdata changed in the cycle after grant: mem_addr and mem_din keep the grant-time values until b_ack.
